// File: rtl/ctrl_pkg.sv
// Shared constants for the control unit: opcodes, control-word bit positions
// and the T-state count of the ring-counter sequencer.
package ctrl_pkg;

    localparam int CW_W     = 16;
    localparam int T_STATES = 6;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_HLT     = 15;
    localparam int CW_MAR_IN  = 14;
    localparam int CW_RAM_IN  = 13;
    localparam int CW_RAM_OUT = 12;
    localparam int CW_IR_OUT  = 11;
    localparam int CW_IR_IN   = 10;
    localparam int CW_A_IN    = 9;
    localparam int CW_A_OUT   = 8;
    localparam int CW_ALU_OUT = 7;
    localparam int CW_SUB     = 6;
    localparam int CW_B_IN    = 5;
    localparam int CW_OUT_IN  = 4;
    localparam int CW_PC_INC  = 3;
    localparam int CW_PC_OUT  = 2;
    localparam int CW_JUMP    = 1;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode table: one-hot T-state plus opcode to control word,
// end-of-instruction flag and illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [T_STATES-1:0] t_state_i,
    input  logic [3:0]          opcode_i,
    output logic [CW_W-1:0]     cw_o,
    output logic                done_o,
    output logic                illegal_o
);

    always_comb begin
        cw_o      = '0;
        done_o    = 1'b0;
        illegal_o = 1'b0;
        if (t_state_i[0]) begin
            cw_o[CW_PC_OUT] = 1'b1;
            cw_o[CW_MAR_IN] = 1'b1;
        end else if (t_state_i[1]) begin
            cw_o[CW_PC_INC] = 1'b1;
        end else if (t_state_i[2]) begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_IR_IN]   = 1'b1;
        end else if (t_state_i[3]) begin
            case (opcode_i)
                OP_NOP: done_o = 1'b1;
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    cw_o[CW_IR_OUT] = 1'b1;
                    cw_o[CW_MAR_IN] = 1'b1;
                end
                OP_LDI: begin
                    cw_o[CW_IR_OUT] = 1'b1;
                    cw_o[CW_A_IN]   = 1'b1;
                    done_o          = 1'b1;
                end
                OP_JMP: begin
                    cw_o[CW_IR_OUT] = 1'b1;
                    cw_o[CW_JUMP]   = 1'b1;
                    done_o          = 1'b1;
                end
                OP_OUT: begin
                    cw_o[CW_A_OUT]  = 1'b1;
                    cw_o[CW_OUT_IN] = 1'b1;
                    done_o          = 1'b1;
                end
                OP_HLT: cw_o[CW_HLT] = 1'b1;
                // Undefined opcodes retire as NOP so the sequencer keeps running.
                default: begin
                    illegal_o = 1'b1;
                    done_o    = 1'b1;
                end
            endcase
        end else if (t_state_i[4]) begin
            case (opcode_i)
                OP_LDA: begin
                    cw_o[CW_RAM_OUT] = 1'b1;
                    cw_o[CW_A_IN]    = 1'b1;
                    done_o           = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    cw_o[CW_RAM_OUT] = 1'b1;
                    cw_o[CW_B_IN]    = 1'b1;
                end
                OP_STA: begin
                    cw_o[CW_A_OUT]  = 1'b1;
                    cw_o[CW_RAM_IN] = 1'b1;
                    done_o          = 1'b1;
                end
                default: ;
            endcase
        end else if (t_state_i[5]) begin
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                cw_o[CW_ALU_OUT] = 1'b1;
                cw_o[CW_A_IN]    = 1'b1;
                cw_o[CW_SUB]     = (opcode_i == OP_SUB);
                done_o           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_unit.sv
// Registered control unit: wraps the microcode decode with opcode capture,
// halt latch, sticky error flags and the retired-instruction counter.
module control_unit #(
    parameter int CW_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             dummy_clk,
    input  logic             FPGA_inp_zero,
    input  logic             seq1,
    input  logic             seq2,
    input  logic             seq3,
    input  logic             seq4,
    input  logic             seq5,
    input  logic             seq6,
    input  logic [3:0]       ir_opcode,
    output logic [CW_W-1:0]  cw,
    output logic             seq_done,
    output logic             halted,
    output logic             seq_err,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);
    import ctrl_pkg::*;

    logic [T_STATES-1:0] t_state;
    logic                one_hot;
    logic [3:0]          dec_op;
    logic [CW_W-1:0]     dec_cw;
    logic                dec_done;
    logic                dec_illegal;

    logic [CW_W-1:0]  cw_q, cw_d;
    logic             done_q, done_d;
    logic             halted_q, halted_d;
    logic             seq_err_q, seq_err_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             retired_q, retired_d;

    assign t_state = {seq6, seq5, seq4, seq3, seq2, seq1};
    assign one_hot = (t_state != '0) && ((t_state & (t_state - 1'b1)) == '0);
    // Execute steps past T4 use the captured opcode, not the live IR.
    assign dec_op  = t_state[3] ? ir_opcode : op_q;

    ctrl_decode u_decode (
        .t_state_i (t_state),
        .opcode_i  (dec_op),
        .cw_o      (dec_cw),
        .done_o    (dec_done),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        cw_d      = '0;
        done_d    = 1'b0;
        halted_d  = halted_q;
        seq_err_d = seq_err_q;
        illegal_d = illegal_q;
        op_d      = op_q;
        retired_d = retired_q;
        if (halted_q) begin
            cw_d[CW_HLT] = 1'b1;
        end else if (!one_hot) begin
            seq_err_d = 1'b1;
        end else if (t_state[0]) begin
            cw_d      = dec_cw;
            retired_d = 1'b0;
        end else if (!retired_q) begin
            // Once an instruction has retired, every T-state until the next T1
            // is dead: this also keeps seq_done a single pulse on repeated states.
            cw_d      = dec_cw;
            done_d    = dec_done;
            retired_d = dec_done;
            illegal_d = illegal_q | dec_illegal;
            if (t_state[3]) begin
                op_d     = ir_opcode;
                halted_d = (ir_opcode == OP_HLT);
            end
        end
        cnt_d = cnt_q + CNT_W'(done_d);
    end

    always_ff @(posedge dummy_clk) begin
        if (FPGA_inp_zero) begin
            cw_q      <= '0;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
            seq_err_q <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            retired_q <= 1'b0;
        end else begin
            cw_q      <= cw_d;
            done_q    <= done_d;
            halted_q  <= halted_d;
            seq_err_q <= seq_err_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    assign cw          = cw_q;
    assign seq_done    = done_q;
    assign halted      = halted_q;
    assign seq_err     = seq_err_q;
    assign illegal_op  = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: each driven cycle pushes its
// hand-computed response, a monitor pops and compares one cycle later.
module tb_control_unit;

  localparam int EXP_W = 28;

  logic        clk;
  logic        rst;
  logic [5:0]  seq;
  logic [3:0]  op;
  logic [15:0] cw;
  logic        seq_done;
  logic        halted;
  logic        seq_err;
  logic        illegal_op;
  logic [7:0]  instr_count;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic       exp_h  = 1'b0;
  logic       exp_se = 1'b0;
  logic       exp_il = 1'b0;
  logic [7:0] exp_cnt = 8'd0;

  control_unit #(.CW_W(16), .CNT_W(8)) dut (
    .dummy_clk     (clk),
    .FPGA_inp_zero (rst),
    .seq1          (seq[0]),
    .seq2          (seq[1]),
    .seq3          (seq[2]),
    .seq4          (seq[3]),
    .seq5          (seq[4]),
    .seq6          (seq[5]),
    .ir_opcode     (op),
    .cw            (cw),
    .seq_done      (seq_done),
    .halted        (halted),
    .seq_err       (seq_err),
    .illegal_op    (illegal_op),
    .instr_count   (instr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input logic [5:0] s, input logic [3:0] o, input logic r,
                      input logic [15:0] exp_cw, input logic exp_done);
    @(negedge clk);
    seq = s;
    op  = o;
    rst = r;
    if (r) begin
      exp_h   = 1'b0;
      exp_se  = 1'b0;
      exp_il  = 1'b0;
      exp_cnt = 8'd0;
      exp_q.push_back({16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    end else begin
      if (exp_done) exp_cnt = exp_cnt + 8'd1;
      exp_q.push_back({exp_cw, exp_done, exp_h, exp_se, exp_il, exp_cnt});
    end
  endtask

  task automatic fetch(input logic [3:0] o);
    step(6'b000001, o, 1'b0, 16'h4004, 1'b0);
    step(6'b000010, o, 1'b0, 16'h0008, 1'b0);
    step(6'b000100, o, 1'b0, 16'h1400, 1'b0);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {cw, seq_done, halted, seq_err, illegal_op, instr_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got cw=%h done=%b halted=%b seq_err=%b illegal=%b cnt=%0d, required cw=%h done=%b halted=%b seq_err=%b illegal=%b cnt=%0d",
                 $time, a[27:12], a[11], a[10], a[9], a[8], a[7:0],
                 e[27:12], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    seq = 6'b0;
    op  = 4'h0;

    step(6'b000000, 4'h0, 1'b1, 16'h0, 1'b0);
    step(6'b000000, 4'h0, 1'b1, 16'h0, 1'b0);

    // ADD, with ir_opcode changing after T4 (must be ignored)
    fetch(4'h2);
    step(6'b001000, 4'h2, 1'b0, 16'h4800, 1'b0);
    step(6'b010000, 4'h5, 1'b0, 16'h1020, 1'b0);
    step(6'b100000, 4'h5, 1'b0, 16'h0280, 1'b1);

    // LDI then a stray T5 and a repeated T4
    fetch(4'h5);
    step(6'b001000, 4'h5, 1'b0, 16'h0A00, 1'b1);
    step(6'b010000, 4'h5, 1'b0, 16'h0000, 1'b0);
    step(6'b001000, 4'h5, 1'b0, 16'h0000, 1'b0);

    // SUB
    fetch(4'h3);
    step(6'b001000, 4'h3, 1'b0, 16'h4800, 1'b0);
    step(6'b010000, 4'h3, 1'b0, 16'h1020, 1'b0);
    step(6'b100000, 4'h3, 1'b0, 16'h02C0, 1'b1);

    // LDA, STA, JMP, OUT
    fetch(4'h1);
    step(6'b001000, 4'h1, 1'b0, 16'h4800, 1'b0);
    step(6'b010000, 4'h1, 1'b0, 16'h1200, 1'b1);
    fetch(4'h4);
    step(6'b001000, 4'h4, 1'b0, 16'h4800, 1'b0);
    step(6'b010000, 4'h4, 1'b0, 16'h2100, 1'b1);
    fetch(4'h6);
    step(6'b001000, 4'h6, 1'b0, 16'h0802, 1'b1);
    fetch(4'hE);
    step(6'b001000, 4'hE, 1'b0, 16'h0110, 1'b1);

    // illegal opcode retires as NOP, then ADD still works
    fetch(4'h8);
    exp_il = 1'b1;
    step(6'b001000, 4'h8, 1'b0, 16'h0000, 1'b1);
    fetch(4'h2);
    step(6'b001000, 4'h2, 1'b0, 16'h4800, 1'b0);
    step(6'b010000, 4'h2, 1'b0, 16'h1020, 1'b0);
    step(6'b100000, 4'h2, 1'b0, 16'h0280, 1'b1);

    // malformed T-state patterns
    exp_se = 1'b1;
    step(6'b000101, 4'h2, 1'b0, 16'h0000, 1'b0);
    step(6'b000000, 4'h2, 1'b0, 16'h0000, 1'b0);
    step(6'b110000, 4'h2, 1'b0, 16'h0000, 1'b0);

    // counter wrap over 256 NOPs
    step(6'b000000, 4'h0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      fetch(4'h0);
      step(6'b001000, 4'h0, 1'b0, 16'h0000, 1'b1);
    end

    // reset during T5 of SUB
    fetch(4'h3);
    step(6'b001000, 4'h3, 1'b0, 16'h4800, 1'b0);
    step(6'b010000, 4'h3, 1'b1, 16'h0, 1'b0);
    step(6'b000001, 4'h3, 1'b0, 16'h4004, 1'b0);

    // HLT latches, ignores everything until reset
    fetch(4'hF);
    exp_h = 1'b1;
    step(6'b001000, 4'hF, 1'b0, 16'h8000, 1'b0);
    step(6'b000001, 4'h2, 1'b0, 16'h8000, 1'b0);
    step(6'b000010, 4'h2, 1'b0, 16'h8000, 1'b0);
    step(6'b000100, 4'h2, 1'b0, 16'h8000, 1'b0);
    step(6'b000011, 4'h8, 1'b0, 16'h8000, 1'b0);
    step(6'b000001, 4'h0, 1'b1, 16'h0, 1'b0);
    step(6'b000001, 4'h0, 1'b0, 16'h4004, 1'b0);

    // drain and report
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Decodes the six one-hot T-state lines from the ring-counter sequencer, together with the instruction-register opcode, into the processor's 16-bit control word. It sits directly downstream of the sequencer and drives every register-load, bus-enable and ALU control line in the datapath. Outputs are registered. The block also:
- latches halt;
- requests an early sequencer restart for short instructions;
- flags malformed T-state patterns and illegal opcodes;
- counts retired instructions.

## Interface
Parameters:
- CW_W, 16, control word width; fixed by bit map below
- CNT_W, 8, retired-instruction counter width

Ports:
- dummy_clk  in  1  system clock; all state updates on rising edge
- FPGA_inp_zero  in  1  reset, synchronous, active-high
- seq1..seq6  in  1 each  T-state lines T1..T6 from sequencer, expected one-hot
- ir_opcode  in  4  upper nibble of instruction register, valid from T4
- cw  out  CW_W  registered control word
- seq_done  out  1  registered end-of-instruction; sequencer ORs it into its restart
- halted  out  1  sticky halt
- seq_err  out  1  sticky: T-state input not one-hot
- illegal_op  out  1  sticky: undefined opcode decoded
- instr_count  out  CNT_W  retired instructions, wraps

## Operation
- cw bit map: 15 hlt, 14 mar_in, 13 ram_in, 12 ram_out, 11 ir_out, 10 ir_in, 9 a_in, 8 a_out, 7 alu_out, 6 sub, 5 b_in, 4 out_in, 3 pc_inc, 2 pc_out, 1 jump, 0 reserved (always 0).
- Fetch, all opcodes:
  - T1: pc_out|mar_in
  - T2: pc_inc
  - T3: ram_out|ir_in
- Execute steps (T4 / T5 / T6); done marks the step that asserts seq_done:
  - 0000 NOP: T4 none, done
  - 0001 LDA: T4 ir_out|mar_in; T5 ram_out|a_in, done
  - 0010 ADD: T4 ir_out|mar_in; T5 ram_out|b_in; T6 alu_out|a_in, done
  - 0011 SUB: as ADD, with T6 alu_out|sub|a_in, done
  - 0100 STA: T4 ir_out|mar_in; T5 a_out|ram_in, done
  - 0101 LDI: T4 ir_out|a_in, done
  - 0110 JMP: T4 ir_out|jump, done
  - 1110 OUT: T4 a_out|out_in, done
  - 1111 HLT: T4 hlt; sets halted
  - other: treated as NOP; sets illegal_op
- Opcode handling:
  - T4 decode uses ir_opcode directly; it is captured into op_q in the T4 cycle.
  - T5/T6 decode uses op_q, so ir_opcode changes after T4 are ignored.
- Any T-state that arrives after the opcode's done step (sequencer ignored seq_done) decodes to cw=0.
- instr_count increments by 1 in each cycle seq_done is registered high, and wraps from 2^CNT_W−1 to 0.
- Halted:
  - cw = only bit 15 set (16'h8000) and seq_done=0, regardless of inputs.
  - Exit only via reset.
- Malformed input (zero or more than one seq line high, not halted):
  - cw=0, seq_done=0, seq_err set.
  - op_q is unchanged.
- Error flags are sticky until reset.

## Timing
- Latency: each rising edge samples seq1..6 and ir_opcode; the resulting cw/seq_done appears after that edge, i.e. one cycle after the sample.
- seq_done is a single-cycle pulse per instruction. It is not held across a repeated T-state.
- HLT: halted is high on the same edge that first registers the T4 hlt word.
- Reset, including mid-instruction, takes effect at the next edge:
  - cw=0, seq_done=0, halted=0, seq_err=0, illegal_op=0, instr_count=0, op_q=0.
  - Reset overrides all other updates in that cycle.
- Reset and seq_done in the same cycle: the counter stays 0.

## Structure
- Package ctrl_pkg:
  - opcode localparams
  - cw bit-index localparams
  - T-state count (6)
  - CW_W
- Sub-module ctrl_decode (purely combinational): {one-hot T-state, opcode} → {cw_next, done_next, illegal}.
- Top wraps ctrl_decode with the op_q, cw, seq_done, halt, error and counter registers, plus the one-hot check.

## Test plan
- Reset, then T1..T6 with opcode 0010 (ADD). Required cw sequence, each one cycle after its T-state:
  - 16'h4004, 16'h0008, 16'h1400, 16'h4800, 16'h1020, 16'h0280
  - seq_done high only with the last word; instr_count=1.
- LDI (0101): T4 → cw=16'h0A00 with seq_done. A stray T5 afterwards → cw=0, no second seq_done.
- HLT (1111) at T4 → cw=16'h8000 and halted=1. Later T1..T3 keep cw=16'h8000 until FPGA_inp_zero → all outputs 0.
- Opcode 1000 at T4 → cw=0, seq_done=1, illegal_op=1 and stays 1. The next ADD still executes correctly.
- seq1 and seq3 both high for one cycle → cw=0, seq_err=1. Then seq=000000 → cw=0, seq_err still 1.
- Run 256 NOP instructions → instr_count wraps to 0. Assert reset during T5 of SUB → next cw=0 and instr_count=0.
